layer_out_serializer: RTL and testbench

- Transmit end of the network output path: takes one full layer output vector (CH channels of DW-bit IEEE-754 floats, all presented in parallel) and streams it out one channel per beat on a DW-bit port.
- Sits between the final detection layers (255-channel outputs) and the DW-bit top-level data_out.
- It is the counterpart of the input path, which widens 24-bit pixels into parallel floats for the first layer.
- Uses a valid/ready handshake on both sides and holds the vector in a local buffer, so the upstream layer is released as soon as the vector is captured.

---
 rtl/layer_out_serializer.sv | 99 +++++++++
 tb/tb_layer_out_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer.sv
// Parallel-to-serial transmit stage: captures a CH-channel output vector into a
// local buffer and streams it out one DW-bit word per valid/ready beat.
module layer_out_serializer #(
    parameter int CH = 255,
    parameter int DW = 32,
    parameter int IW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [CH*DW-1:0]   data_in,
    input  logic               valid_in,
    output logic               ready_in,
    output logic [DW-1:0]      data_out,
    output logic               valid_out,
    input  logic               ready_out,
    output logic               last_out,
    output logic [IW-1:0]      ch_idx
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic [DW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [DW-1:0]   buf_q [CH];
    logic [DW-1:0]   buf_d [CH];
    logic            capture;
    logic            beat;

    // The last beat frees the buffer, so a new vector may be taken that same cycle.
    assign ready_in  = (state_q == IDLE) || (ready_out && last_q);
    assign capture   = valid_in && ready_in;
    assign beat      = valid_q && ready_out;
    assign cnt_nxt   = cnt_q + IW'(1);

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign ch_idx    = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        buf_d   = buf_q;

        if (capture) begin
            // Word 0 goes straight to the output register; the buffer is not yet loaded.
            for (int unsigned k = 0; k < CH; k++) begin
                buf_d[k] = data_in[k*DW +: DW];
            end
            state_d = SEND;
            cnt_d   = '0;
            data_d  = data_in[DW-1:0];
            valid_d = 1'b1;
            last_d  = (CH == 1);
        end else if (beat) begin
            if (last_q) begin
                state_d = IDLE;
                cnt_d   = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                cnt_d   = cnt_nxt;
                data_d  = buf_q[cnt_nxt];
                last_d  = (cnt_nxt == IW'(CH - 1));
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge Clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Self-checking bench for layer_out_serializer: a CH=4 instance for the handshake
// scenarios and a CH=255 instance for the full-width vector.
module tb_layer_out_serializer;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4*DW-1:0]   din4;
    logic              vin4, rin4, vout4, rout4, last4;
    logic [DW-1:0]     dout4;
    logic [1:0]        idx4;

    logic [255*DW-1:0] din2;
    logic              vin2, rin2, vout2, rout2, last2;
    logic [DW-1:0]     dout2;
    logic [7:0]        idx2;

    layer_out_serializer #(.CH(4), .DW(DW)) dut4 (
        .Clk(clk), .Rst(rst_n), .data_in(din4), .valid_in(vin4), .ready_in(rin4),
        .data_out(dout4), .valid_out(vout4), .ready_out(rout4), .last_out(last4),
        .ch_idx(idx4)
    );

    layer_out_serializer #(.CH(255), .DW(DW)) dut255 (
        .Clk(clk), .Rst(rst_n), .data_in(din2), .valid_in(vin2), .ready_in(rin2),
        .data_out(dout2), .valid_out(vout2), .ready_out(rout2), .last_out(last2),
        .ch_idx(idx2)
    );

    int ntot = 0;
    int npass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: queue of words still owed for the vector in flight, plus its position.
    logic [DW-1:0] m4[$];
    logic [DW-1:0] m2[$];
    int p4 = 0;
    int p2 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4.delete(); p4 = 0;
            m2.delete(); p2 = 0;
        end else begin
            bit bt, acc;
            bt  = (m4.size() > 0) && rout4;
            acc = vin4 && ((m4.size() == 0) || (rout4 && m4.size() == 1));
            if (bt) begin void'(m4.pop_front()); p4++; end
            if (acc) begin
                for (int k = 0; k < 4; k++) m4.push_back(din4[k*DW +: DW]);
                p4 = 0;
            end
            bt  = (m2.size() > 0) && rout2;
            acc = vin2 && ((m2.size() == 0) || (rout2 && m2.size() == 1));
            if (bt) begin void'(m2.pop_front()); p2++; end
            if (acc) begin
                for (int k = 0; k < 255; k++) m2.push_back(din2[k*DW +: DW]);
                p2 = 0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] got4[$];
    bit            gl4[$];
    int            gc4[$];

    // Single compare process against the model, plus a record of observed beats.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m4_valid", vout4, m4.size() > 0);
            chk("m4_ready", rin4, (m4.size() == 0) || (rout4 && m4.size() == 1));
            if (m4.size() > 0) begin
                chk("m4_data", dout4, m4[0]);
                chk("m4_idx", idx4, p4);
                chk("m4_last", last4, p4 == 3);
            end
            chk("m2_valid", vout2, m2.size() > 0);
            chk("m2_ready", rin2, (m2.size() == 0) || (rout2 && m2.size() == 1));
            if (m2.size() > 0) begin
                chk("m2_data", dout2, m2[0]);
                chk("m2_idx", idx2, p2);
                chk("m2_last", last2, p2 == 254);
            end
            if (vout4 && rout4) begin
                got4.push_back(dout4);
                gl4.push_back(last4);
                gc4.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [DW-1:0] w[4];
    logic [DW-1:0] ab[8];
    int pat[7];

    initial begin
        w   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        ab  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
        pat = '{1, 0, 0, 1, 0, 1, 1};
        vin4 = 1'b0; rout4 = 1'b0; din4 = '0;
        vin2 = 1'b0; rout2 = 1'b0; din2 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_in", rin4, 1);
        chk("rst_valid_out", vout4, 0);
        chk("rst_last_out", last4, 0);
        chk("rst_data_out", dout4, 0);
        chk("rst_ch_idx", idx4, 0);
        rst_n = 1'b1;
        tick();

        // 1: single vector, no backpressure
        got4.delete();
        din4 = {w[3], w[2], w[1], w[0]};
        vin4 = 1'b1; rout4 = 1'b1;
        tick();
        vin4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_data", dout4, w[k]);
            chk("t1_idx", idx4, k);
            chk("t1_last", last4, k == 3);
            tick();
        end
        #1;
        chk("t1_end_valid", vout4, 0);
        chk("t1_end_ready", rin4, 1);
        tick();

        // 2: backpressure
        got4.delete();
        vin4 = 1'b1;
        tick();
        vin4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rout4 = pat[i][0];
            tick();
        end
        rout4 = 1'b1;
        repeat (3) tick();
        chk("t2_beats", got4.size(), 4);
        for (int k = 0; k < 4; k++) chk("t2_word", (k < got4.size()) ? got4[k] : 'x, w[k]);

        // 3: back-to-back
        got4.delete(); gl4.delete(); gc4.delete();
        din4 = {ab[3], ab[2], ab[1], ab[0]};
        vin4 = 1'b1;
        tick();
        din4 = {ab[7], ab[6], ab[5], ab[4]};
        repeat (4) tick();
        vin4 = 1'b0;
        repeat (6) tick();
        chk("t3_beats", got4.size(), 8);
        if (got4.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t3_word", got4[k], ab[k]);
                chk("t3_last", gl4[k], (k == 3) || (k == 7));
            end
            chk("t3_no_bubble", gc4[7] - gc4[0], 7);
        end

        // 4: input offered while busy is ignored
        got4.delete();
        din4 = {32'h14, 32'h13, 32'h12, 32'h11};
        vin4 = 1'b1;
        tick();
        vin4 = 1'b0;
        tick();
        din4 = {4{32'hDEADBEEF}};
        vin4 = 1'b1;
        #1;
        chk("t4_ready_busy", rin4, 0);
        tick();
        vin4 = 1'b0;
        repeat (5) tick();
        chk("t4_beats", got4.size(), 4);
        for (int k = 0; k < 4; k++) chk("t4_word", (k < got4.size()) ? got4[k] : 'x, 32'h11 + k);

        // 5: asynchronous reset mid-vector
        got4.delete();
        din4 = {32'h24, 32'h23, 32'h22, 32'h21};
        vin4 = 1'b1;
        tick();
        vin4 = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", vout4, 0);
        chk("t5_idx", idx4, 0);
        chk("t5_ready", rin4, 1);
        chk("t5_beats", got4.size(), 1);
        tick();
        rst_n = 1'b1;
        got4.delete();
        din4 = {32'h34, 32'h33, 32'h32, 32'h31};
        vin4 = 1'b1;
        tick();
        vin4 = 1'b0;
        #1;
        chk("t5_restart_idx", idx4, 0);
        chk("t5_restart_data", dout4, 32'h31);
        repeat (5) tick();
        chk("t5_restart_beats", got4.size(), 4);
        for (int k = 0; k < 4; k++) chk("t5_word", (k < got4.size()) ? got4[k] : 'x, 32'h31 + k);

        // 6: full 255-channel vector
        for (int k = 0; k < 255; k++) din2[k*DW +: DW] = DW'(k);
        vin2 = 1'b1; rout2 = 1'b1;
        tick();
        vin2 = 1'b0;
        for (int k = 0; k < 255; k++) begin
            #1;
            chk("t6_data", dout2, k);
            chk("t6_idx", idx2, k);
            chk("t6_last", last2, k == 254);
            tick();
        end
        #1;
        chk("t6_end_valid", vout2, 0);
        chk("t6_end_idx", idx2, 0);
        tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
